// File: rtl/core_wport_arb_pkg.sv
// Shared types for the register-file write-port arbiter: state encoding,
// register address type and the default starvation bound.
package core_wport_arb_pkg;

    typedef logic [4:0] regaddr_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } wport_state_t;

    localparam int unsigned WPORT_MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/core_wport_scoreboard.sv
// Busy flags for registers with an outstanding long-latency write.
// A set and a clear of the same register in one cycle leaves it set.
module core_wport_scoreboard
    import core_wport_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  regaddr_t    set_rd,
    input  logic        clr_en,
    input  regaddr_t    clr_rd,
    output logic [31:0] busy
);

    logic [31:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_rd] = 1'b0;
        if (set_en)
            busy_nxt[set_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: rtl/core_wport_arb.sv
// Arbitrates the single register-file write port between writeback (P) and
// the long-latency unit (L). CORE_WPORT_BYPASS_EN enables same-cycle L writes.
//
// state | meaning
// EMPTY | no L result buffered
// HELD  | L result buffered, still yielding to P writes
// FORCE | L result buffered and has waited MAX_WAIT cycles; wins over P
module core_wport_arb
    import core_wport_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = WPORT_MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_valid,
    input  logic        p_wen,
    input  regaddr_t    p_rd,
    input  logic [31:0] p_wdata,
    output logic        p_ready,
    input  logic        l_valid,
    input  regaddr_t    l_rd,
    input  logic [31:0] l_wdata,
    output logic        l_ready,
    input  logic        iss_valid,
    input  regaddr_t    iss_rd,
    output logic [31:0] busy,
    output logic        rf_wen,
    output regaddr_t    rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    wport_state_t state;
    logic [3:0]   wait_cnt;
    regaddr_t     buf_rd;
    logic [31:0]  buf_wdata;
    logic         buf_valid;
    logic         pw;
    logic         grant_l;
    logic         grant_p;
    logic         byp;
    logic         accept;
    logic         load;

    assign buf_valid = (state != EMPTY);
    assign pw        = p_valid && p_wen;
    assign grant_l   = buf_valid && (!pw || state == FORCE);
    assign grant_p   = pw && !grant_l;
    assign p_ready   = !pw || grant_p;
    assign l_ready   = !buf_valid || grant_l;
    assign accept    = l_valid && l_ready;

`ifdef CORE_WPORT_BYPASS_EN
    assign byp = !buf_valid && l_valid && !pw;
`else
    assign byp = 1'b0;
`endif

    // A bypassed result goes straight to the port and never occupies the buffer.
    assign load = accept && !byp;

    always_comb begin
        rf_waddr  = buf_rd;
        rf_wdata  = buf_wdata;
        if (grant_l) begin
            rf_waddr = buf_rd;
            rf_wdata = buf_wdata;
        end else if (grant_p) begin
            rf_waddr = p_rd;
            rf_wdata = p_wdata;
        end else if (byp) begin
            rf_waddr = l_rd;
            rf_wdata = l_wdata;
        end
    end

    // Gating with rst keeps a P write presented during reset off the port.
    assign rf_wen = (grant_l || grant_p || byp) && (rf_waddr != '0) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            wait_cnt  <= '0;
            buf_rd    <= '0;
            buf_wdata <= '0;
        end else begin
            if (load) begin
                buf_rd    <= l_rd;
                buf_wdata <= l_wdata;
                state     <= HELD;
                wait_cnt  <= '0;
            end else if (grant_l) begin
                state    <= EMPTY;
                wait_cnt <= '0;
            end else if (buf_valid && wait_cnt < MAX_W) begin
                wait_cnt <= wait_cnt + 4'd1;
                state    <= (wait_cnt + 4'd1 == MAX_W) ? FORCE : HELD;
            end
        end
    end

    core_wport_scoreboard u_sb (
        .clk    (clk),
        .rst    (rst),
        .set_en (iss_valid && iss_rd != '0),
        .set_rd (iss_rd),
        .clr_en (grant_l || byp),
        .clr_rd (grant_l ? buf_rd : l_rd),
        .busy   (busy)
    );

endmodule

// File: tb/tb_core_wport_arb.sv
// Directed checks of the write-port arbiter with hand-computed expectations.
module tb_core_wport_arb;
    import core_wport_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_valid, p_wen;
    regaddr_t    p_rd;
    logic [31:0] p_wdata;
    logic        p_ready;
    logic        l_valid;
    regaddr_t    l_rd;
    logic [31:0] l_wdata;
    logic        l_ready;
    logic        iss_valid;
    regaddr_t    iss_rd;
    logic [31:0] busy;
    logic        rf_wen;
    regaddr_t    rf_waddr;
    logic [31:0] rf_wdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    core_wport_arb dut (
        .clk       (clk),
        .rst       (rst),
        .p_valid   (p_valid),
        .p_wen     (p_wen),
        .p_rd      (p_rd),
        .p_wdata   (p_wdata),
        .p_ready   (p_ready),
        .l_valid   (l_valid),
        .l_rd      (l_rd),
        .l_wdata   (l_wdata),
        .l_ready   (l_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy      (busy),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs change there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p_set(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d);
        p_valid = v; p_wen = w; p_rd = rd; p_wdata = d;
    endtask

    task automatic l_set(input logic v, input logic [4:0] rd, input logic [31:0] d);
        l_valid = v; l_rd = rd; l_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        iss_valid = 1'b0; iss_rd = '0;
        p_set(1'b1, 1'b1, 5'd3, 32'h3);
        l_set(1'b0, 5'd0, 32'h0);
        #2;
        check("rst_rf_wen", 32'(rf_wen), 32'd0);
        check("rst_p_ready", 32'(p_ready), 32'd1);
        check("rst_l_ready", 32'(l_ready), 32'd1);
        tick();
        rst = 1'b0;
        p_set(1'b0, 1'b0, 5'd0, 32'h0);
        #2;
        check("rst_busy", busy, 32'h0);

        // L alone: issue rd5, result next cycle, drain the cycle after
        tick();
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        iss_valid = 1'b0;
        check("t1_busy_set", busy, 32'h20);
        l_set(1'b1, 5'd5, 32'hDEADBEEF);
        #2;
        check("t1_l_ready", 32'(l_ready), 32'd1);
`ifdef CORE_WPORT_BYPASS_EN
        check("t1_byp_wen", 32'(rf_wen), 32'd1);
        check("t1_byp_waddr", 32'(rf_waddr), 32'd5);
        tick();
        l_set(1'b0, 5'd0, 32'h0);
        #2;
        check("t1_byp_busy", busy, 32'h0);
        check("t1_byp_idle", 32'(rf_wen), 32'd0);
`else
        check("t1_no_same_cycle", 32'(rf_wen), 32'd0);
        tick();
        l_set(1'b0, 5'd0, 32'h0);
        #2;
        check("t1_wen", 32'(rf_wen), 32'd1);
        check("t1_waddr", 32'(rf_waddr), 32'd5);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
        check("t1_busy_still", busy, 32'h20);
        tick();
        check("t1_busy_clr", busy, 32'h0);
        check("t1_idle", 32'(rf_wen), 32'd0);
`endif

        // Continuous P writes against one buffered L result to rd7
        tick();
        p_set(1'b1, 1'b1, 5'd1, 32'h101);
        l_set(1'b1, 5'd7, 32'h77);
        #2;
        check("t2_c0_p_ready", 32'(p_ready), 32'd1);
        check("t2_c0_waddr", 32'(rf_waddr), 32'd1);
        check("t2_c0_l_ready", 32'(l_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            l_set(1'b0, 5'd0, 32'h0);
            p_set(1'b1, 1'b1, 5'(k + 1), 32'h100 + 32'(k + 1));
            #2;
            check($sformatf("t2_c%0d_p_ready", k), 32'(p_ready), 32'd1);
            check($sformatf("t2_c%0d_waddr", k), 32'(rf_waddr), 32'(k + 1));
            check($sformatf("t2_c%0d_l_ready", k), 32'(l_ready), 32'd0);
        end
        tick();
        p_set(1'b1, 1'b1, 5'd6, 32'h106);
        #2;
        check("t2_force_p_ready", 32'(p_ready), 32'd0);
        check("t2_force_waddr", 32'(rf_waddr), 32'd7);
        check("t2_force_wdata", rf_wdata, 32'h77);
        check("t2_force_wen", 32'(rf_wen), 32'd1);
        tick();
        check("t2_resume_p_ready", 32'(p_ready), 32'd1);
        check("t2_resume_waddr", 32'(rf_waddr), 32'd6);
        check("t2_resume_wdata", rf_wdata, 32'h106);

        // P without write enable never stalls a buffered L drain
        tick();
        p_set(1'b1, 1'b1, 5'd2, 32'h202);
        l_set(1'b1, 5'd9, 32'h99);
        tick();
        p_set(1'b1, 1'b0, 5'd2, 32'h0);
        l_set(1'b0, 5'd0, 32'h0);
        #2;
        check("t3_p_ready", 32'(p_ready), 32'd1);
        check("t3_wen", 32'(rf_wen), 32'd1);
        check("t3_waddr", 32'(rf_waddr), 32'd9);
        check("t3_wdata", rf_wdata, 32'h99);
        tick();
        p_set(1'b0, 1'b0, 5'd0, 32'h0);

`ifndef CORE_WPORT_BYPASS_EN
        // Back-to-back L results, P idle
        tick();
        l_set(1'b1, 5'd10, 32'hA);
        #2;
        check("t4_c0_l_ready", 32'(l_ready), 32'd1);
        tick();
        l_set(1'b1, 5'd11, 32'hB);
        #2;
        check("t4_c1_l_ready", 32'(l_ready), 32'd1);
        check("t4_c1_waddr", 32'(rf_waddr), 32'd10);
        check("t4_c1_wen", 32'(rf_wen), 32'd1);
        tick();
        l_set(1'b0, 5'd0, 32'h0);
        #2;
        check("t4_c2_waddr", 32'(rf_waddr), 32'd11);
        check("t4_c2_wdata", rf_wdata, 32'hB);
        check("t4_c2_wen", 32'(rf_wen), 32'd1);
        tick();
        check("t4_c3_wen", 32'(rf_wen), 32'd0);
`endif

        // L result to x0: handshake completes, no write, no busy bit
        tick();
        p_set(1'b1, 1'b1, 5'd4, 32'h404);
        l_set(1'b1, 5'd0, 32'h55);
        tick();
        p_set(1'b0, 1'b0, 5'd0, 32'h0);
        l_set(1'b0, 5'd0, 32'h0);
        #2;
        check("t5_x0_wen", 32'(rf_wen), 32'd0);
        check("t5_x0_l_ready", 32'(l_ready), 32'd1);
        check("t5_x0_busy", busy, 32'h0);

        // Issue of rd7 in the same cycle as an L drain of rd7: set wins
        tick();
        p_set(1'b1, 1'b1, 5'd4, 32'h404);
        l_set(1'b1, 5'd7, 32'h7);
        tick();
        p_set(1'b0, 1'b0, 5'd0, 32'h0);
        l_set(1'b0, 5'd0, 32'h0);
        iss_valid = 1'b1; iss_rd = 5'd7;
        #2;
        check("t5_drain_waddr", 32'(rf_waddr), 32'd7);
        tick();
        iss_valid = 1'b0; iss_rd = '0;
        check("t5_set_wins", busy, 32'h80);

        // Reset with a buffered result and busy=0x80
        p_set(1'b1, 1'b1, 5'd4, 32'h404);
        l_set(1'b1, 5'd12, 32'hC);
        tick();
        l_set(1'b0, 5'd0, 32'h0);
        check("t6_held_l_ready", 32'(l_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_wen", 32'(rf_wen), 32'd0);
        check("t6_rst_p_ready", 32'(p_ready), 32'd1);
        check("t6_rst_l_ready", 32'(l_ready), 32'd1);
        check("t6_rst_busy", busy, 32'h0);
        tick();
        rst = 1'b0;
        p_set(1'b0, 1'b0, 5'd0, 32'h0);
        #2;
        check("t6_post_wen", 32'(rf_wen), 32'd0);
        check("t6_post_busy", busy, 32'h0);
        p_set(1'b1, 1'b1, 5'd4, 32'h404);
        l_set(1'b1, 5'd13, 32'hD);
        #1;
        check("t6_post_l_ready", 32'(l_ready), 32'd1);
        tick();
        p_set(1'b0, 1'b0, 5'd0, 32'h0);
        l_set(1'b0, 5'd0, 32'h0);
        #2;
        check("t6_new_waddr", 32'(rf_waddr), 32'd13);
        check("t6_new_wdata", rf_wdata, 32'hD);
        tick();

`ifdef CORE_WPORT_BYPASS_EN
        // Same-cycle bypass to rd3
        l_set(1'b1, 5'd3, 32'h33);
        #2;
        check("byp_wen", 32'(rf_wen), 32'd1);
        check("byp_waddr", 32'(rf_waddr), 32'd3);
        check("byp_wdata", rf_wdata, 32'h33);
        tick();
        l_set(1'b0, 5'd0, 32'h0);
        #2;
        check("byp_no_buffer", 32'(rf_wen), 32'd0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
